tpu_core_nxn: RTL and testbench
===============================

// Module: tpu_core_nxn
// PURPOSE
//  Parametrised NxN successor of the 2x2 TPU compute core. It loads A (NxN) and
//  B (NxN) as a DW-bit element stream, multiplies them on an NxN output-stationary
//  systolic array fed with skewed wavefronts, and streams C = A*B (or A*B^T)
//  back out with a valid/ready handshake. Sits between the host byte interface
//  and the chip-top pin mux.
// PARAMETERS
//  N     4   array dimension; legal range 2..8
//  DW    8   element width; inputs and outputs are signed two's complement
//  ACC_W 20  accumulator width; must be >= 2*DW+$clog2(N)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      in_data valid
//  in_ready   out  1      core accepts an element this cycle
//  in_data    in   DW     element; A row-major first, then B row-major
//  transpose  in   1      1: compute A*B^T
//  relu       in   1      1: clamp negative results to 0
//  out_valid  out  1      out_data holds a result element
//  out_ready  in   1      consumer accepts out_data
//  out_data   out  DW     saturated C[i][j], row-major order
//  done       out  1      one-cycle pulse after the last result is accepted
//  state      out  2      FSM state: 0 IDLE, 1 LOAD, 2 COMPUTE, 3 OUTPUT
// BEHAVIOUR
//  - Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, done=0;
//    all counters and accumulators cleared. Reset asserted mid-operation aborts
//    the operation and discards all loaded data.
//  - Handshakes: an element transfers on the rising edge where valid&&ready.
//    in_ready=1 only in IDLE and LOAD. in_valid in COMPUTE/OUTPUT is ignored.
//  - IDLE -> LOAD on the first input handshake; that element is A[0][0].
//  - LOAD accepts exactly 2*N*N elements into the A and B buffers. The edge that
//    accepts the last element goes to COMPUTE. That same edge samples transpose
//    and relu and clears all PE accumulators.
//  - COMPUTE lasts 3N-1 cycles: 3N-2 skewed feed cycles plus 1 drain cycle.
//    Row i of A enters the west edge delayed by i cycles. Column j of B (row j
//    of B when transpose=1) enters the north edge delayed by j cycles.
//    Zeros are injected outside each wavefront.
//  - PE arithmetic: acc += a*b, signed, DW x DW -> 2*DW product, sign-extended,
//    and wrapping mod 2^ACC_W.
//  - OUTPUT: out_valid rises 3N edges after the last-load edge (N=2: 6 edges).
//    out_data then walks C row-major and advances one element per out handshake.
//    With out_ready=0, out_data and out_valid hold stable.
//  - Output conversion: if relu=1 and acc<0, the result is 0. The value is then
//    saturated to [-2^(DW-1), 2^(DW-1)-1].
//  - After the N*N-th out handshake: state returns to IDLE, out_valid drops, and
//    done=1 for exactly one cycle. in_ready becomes 1 on the same edge.
//  - A new load may begin the cycle after done; the core holds no carry-over state.
// TESTING
//  1 N=2, A=[1 2;3 4], B=[5 6;7 8], transpose=0, out_ready=1
//    -> out 19,22,43,50; done one cycle after 50 is accepted.
//  2 Same data with transpose=1 -> out 17,23,39,53.
//  3 A=[-1 0;0 1], B=I: relu=0 -> 0xFF,0,0,1; relu=1 -> 0,0,0,1.
//  4 A=B=all 127 (N=2) -> every out 0x7F (acc=32258).
//    A all -128, B all 127 -> every out 0x80.
//  5 Backpressure: toggle out_ready randomly
//    -> out_data stable while stalled, order unchanged, single done pulse.
//    Also assert rst during COMPUTE -> state=0, out_valid=0, in_ready=1;
//    a fresh load then gives correct results.
//  6 N=4, A=I, B=rows {1..4},{5..8},{9..12},{13..16}
//    -> out 1..16 in order; out_valid first high exactly 12 edges after the
//    32nd input handshake; in_ready=0 throughout COMPUTE/OUTPUT.

Source files
------------

// File: rtl/tpu_core_nxn.sv
// tpu_core_nxn: NxN output-stationary systolic matrix-multiply core.
// Loads A then B (row-major, 2*N*N DW-bit signed elements) and computes C = A*B
// (or A*B^T) on an NxN PE grid fed with skewed wavefronts. It then streams
// saturated, optionally ReLU-clamped, results row-major over a valid/ready port.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready/in_data element input stream (A first, then B)
//   transpose, relu           mode inputs, sampled on the last-load edge
//   out_valid/out_ready/out_data result output stream
//   done                      one-cycle pulse after the last result is accepted
//   state                     0 IDLE, 1 LOAD, 2 COMPUTE, 3 OUTPUT
module tpu_core_nxn #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          transpose,
  input  logic          relu,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          done,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

  localparam int NN    = N * N;
  localparam int AW    = $clog2(2 * NN);
  localparam int KW    = $clog2(3 * N);
  localparam int OW    = $clog2(NN);
  localparam logic [AW-1:0] LAST_LD  = AW'(2 * NN - 1);
  localparam logic [KW-1:0] LAST_K   = KW'(3 * N - 2);
  localparam logic [OW-1:0] LAST_OUT = OW'(NN - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_t st;
  logic [AW-1:0] load_cnt;
  logic [KW-1:0] k;
  logic [OW-1:0] out_idx;
  logic          tr_q, relu_q;

  logic signed [DW-1:0]    mem   [2*NN];
  logic signed [DW-1:0]    west  [N];
  logic signed [DW-1:0]    north [N];
  logic signed [DW-1:0]    a_reg [N][N];
  logic signed [DW-1:0]    b_reg [N][N];
  logic signed [DW-1:0]    a_in  [N][N];
  logic signed [DW-1:0]    b_in  [N][N];
  logic signed [2*DW-1:0]  prod  [N][N];
  logic signed [ACC_W-1:0] acc   [N][N];
  logic signed [ACC_W-1:0] acc_flat [NN];
  logic signed [ACC_W-1:0] sel_acc;
  logic [OW-1:0]           sel_idx;
  logic [AW-1:0]           wr_addr;
  logic                    last_load;

  assign state     = st;
  assign last_load = (st == S_LOAD) && in_valid && (load_cnt == LAST_LD);
  assign wr_addr   = (st == S_IDLE) ? '0 : load_cnt;

  // ReLU first, then clamp into the signed DW-bit range.
  function automatic logic [DW-1:0] conv(input logic signed [ACC_W-1:0] v, input logic r);
    logic signed [ACC_W-1:0] t;
    t = (r && v[ACC_W-1]) ? '0 : v;
    if (t > SAT_MAX)      return SAT_MAX[DW-1:0];
    else if (t < SAT_MIN) return SAT_MIN[DW-1:0];
    else                  return t[DW-1:0];
  endfunction

  // NOTE: the operand buffer has no reset; every entry is rewritten by a full
  // load before it is read, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) mem[wr_addr] <= in_data;
  end

  // Skewed edge feeds: row i of A (and column/row j of B) lags by i (j) cycles,
  // so A[i][m] and B[m][j] meet in PE(i,j) on feed cycle i+j+m.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      west[i]  = '0;
      north[i] = '0;
      if (st == S_COMPUTE && int'(k) >= i && int'(k) - i < N) begin
        west[i]  = mem[AW'(i * N + int'(k) - i)];
        north[i] = tr_q ? mem[AW'(NN + i * N + int'(k) - i)]
                        : mem[AW'(NN + (int'(k) - i) * N + i)];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = west[i];
      b_in[0][i] = north[i];
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = a_reg[i][j-1];
        b_in[j][i] = b_reg[j-1][i];
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        prod[i][j]         = (2*DW)'(a_in[i][j]) * (2*DW)'(b_in[i][j]);
        acc_flat[i*N + j]  = acc[i][j];
      end
  end

  // Index of the element presented after this edge: advance on handshake.
  assign sel_idx = (st == S_OUTPUT && out_valid && out_ready) ? out_idx + 1'b1 : out_idx;
  assign sel_acc = acc_flat[sel_idx];

  // PE grid: accumulators and pass-through operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j]   <= '0;
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
        end
    end else if (last_load) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j]   <= '0;
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
        end
    end else if (st == S_COMPUTE) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j]   <= acc[i][j] + {{(ACC_W-2*DW){prod[i][j][2*DW-1]}}, prod[i][j]};
          a_reg[i][j] <= a_in[i][j];
          b_reg[i][j] <= b_in[i][j];
        end
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      load_cnt  <= '0;
      k         <= '0;
      out_idx   <= '0;
      tr_q      <= 1'b0;
      relu_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        S_IDLE: begin
          if (in_valid) begin
            load_cnt <= AW'(1);
            st       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (load_cnt == LAST_LD) begin
              st       <= S_COMPUTE;
              in_ready <= 1'b0;
              tr_q     <= transpose;
              relu_q   <= relu;
              k        <= '0;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          k <= k + 1'b1;
          if (k == LAST_K) begin
            st      <= S_OUTPUT;
            out_idx <= '0;
          end
        end
        S_OUTPUT: begin
          // First OUTPUT cycle presents C[0][0]; later ones advance on handshake.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= conv(sel_acc, relu_q);
          end else if (out_ready) begin
            if (out_idx == LAST_OUT) begin
              out_valid <= 1'b0;
              st        <= S_IDLE;
              done      <= 1'b1;
              in_ready  <= 1'b1;
            end else begin
              out_idx  <= out_idx + 1'b1;
              out_data <= conv(sel_acc, relu_q);
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_core_nxn.sv
// Directed testbench for tpu_core_nxn: an N=2 instance for the arithmetic,
// mode, backpressure and reset scenarios, and an N=4 instance for latency.
module tb_tpu_core_nxn;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // N=2 instance
  logic       in_valid2 = 0, in_ready2, tr2 = 0, relu2 = 0;
  logic [7:0] in_data2 = '0, out_data2;
  logic       out_valid2, out_ready2 = 0, done2;
  logic [1:0] state2;

  // N=4 instance
  logic       in_valid4 = 0, in_ready4, tr4 = 0, relu4 = 0;
  logic [7:0] in_data4 = '0, out_data4;
  logic       out_valid4, out_ready4 = 0, done4;
  logic [1:0] state4;

  tpu_core_nxn #(.N(2), .DW(8), .ACC_W(20)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .transpose(tr2), .relu(relu2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_data(out_data2), .done(done2), .state(state2)
  );

  tpu_core_nxn #(.N(4), .DW(8), .ACC_W(20)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .transpose(tr4), .relu(relu4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4), .done(done4), .state(state4)
  );

  // Matrices are packed {m00, m01, m10, m11}, m00 in the top byte.
  task automatic load2(input logic [31:0] av, input logic [31:0] bv,
                       input logic t, input logic r);
    tr2   = t;
    relu2 = r;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      total++;
      if (in_ready2 !== 1'b1) begin
        bad++;
        $display("FAIL load2_in_ready elem %0d: got %b expected 1", e, in_ready2);
      end
      in_valid2 = 1'b1;
      in_data2  = (e < 4) ? av[8*(3-e) +: 8] : bv[8*(7-e) +: 8];
    end
    @(negedge clk);
    in_valid2 = 1'b0;
  endtask

  task automatic collect2(input logic [31:0] expv, input string name, input bit stall);
    int got = 0;
    int cyc = 0;
    bit prev_stall = 0;
    logic [7:0] prev_d = '0;
    logic rdy;
    while (got < 4 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      total++;
      if (done2 !== 1'b0) begin
        bad++;
        $display("FAIL %s_early_done: got %b expected 0", name, done2);
      end
      if (prev_stall) begin
        total++;
        if (out_valid2 !== 1'b1 || out_data2 !== prev_d) begin
          bad++;
          $display("FAIL %s_stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                   name, out_valid2, out_data2, prev_d);
        end
      end
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready2 = rdy;
      prev_stall = 0;
      if (out_valid2 === 1'b1) begin
        if (rdy) begin
          total++;
          if (out_data2 !== expv[8*(3-got) +: 8]) begin
            bad++;
            $display("FAIL %s_out%0d: got %h expected %h", name, got, out_data2,
                     expv[8*(3-got) +: 8]);
          end
          got++;
        end else begin
          prev_stall = 1;
          prev_d     = out_data2;
        end
      end
    end
    total++;
    if (got < 4) begin
      bad++;
      $display("FAIL %s_timeout: got %0d results expected 4", name, got);
    end
    @(negedge clk);
    out_ready2 = 1'b0;
    total++;
    if (done2 !== 1'b1 || out_valid2 !== 1'b0 || state2 !== 2'd0 || in_ready2 !== 1'b1) begin
      bad++;
      $display("FAIL %s_end: got done=%b valid=%b state=%0d in_ready=%b expected 1 0 0 1",
               name, done2, out_valid2, state2, in_ready2);
    end
    @(negedge clk);
    total++;
    if (done2 !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_pulse: got %b expected 0", name, done2);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (state2 !== 2'd0 || in_ready2 !== 1'b1 || out_valid2 !== 1'b0 ||
        out_data2 !== 8'h00 || done2 !== 1'b0 || state4 !== 2'd0) begin
      bad++;
      $display("FAIL reset: got state=%0d in_ready=%b valid=%b data=%h done=%b state4=%0d expected 0 1 0 00 0 0",
               state2, in_ready2, out_valid2, out_data2, done2, state4);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    load2({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, 1'b0, 1'b0);
    collect2({8'd19, 8'd22, 8'd43, 8'd50}, "basic", 1'b0);
  endtask

  task automatic test_transpose;
    load2({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, 1'b1, 1'b0);
    collect2({8'd17, 8'd23, 8'd39, 8'd53}, "transpose", 1'b0);
  endtask

  task automatic test_relu;
    load2({8'hFF, 8'h00, 8'h00, 8'h01}, {8'h01, 8'h00, 8'h00, 8'h01}, 1'b0, 1'b0);
    collect2({8'hFF, 8'h00, 8'h00, 8'h01}, "relu_off", 1'b0);
    load2({8'hFF, 8'h00, 8'h00, 8'h01}, {8'h01, 8'h00, 8'h00, 8'h01}, 1'b0, 1'b1);
    collect2({8'h00, 8'h00, 8'h00, 8'h01}, "relu_on", 1'b0);
  endtask

  task automatic test_saturation;
    load2({4{8'h7F}}, {4{8'h7F}}, 1'b0, 1'b0);
    collect2({4{8'h7F}}, "sat_pos", 1'b0);
    load2({4{8'h80}}, {4{8'h7F}}, 1'b0, 1'b0);
    collect2({4{8'h80}}, "sat_neg", 1'b0);
  endtask

  task automatic test_back_to_back_stall;
    load2({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, 1'b0, 1'b0);
    collect2({8'd19, 8'd22, 8'd43, 8'd50}, "backpressure", 1'b1);
  endtask

  task automatic test_reset_mid;
    load2({8'd9, 8'd9, 8'd9, 8'd9}, {8'd9, 8'd9, 8'd9, 8'd9}, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (state2 !== 2'd2) begin
      bad++;
      $display("FAIL mid_state_compute: got %0d expected 2", state2);
    end
    rst = 1'b1;
    #1;
    total++;
    if (state2 !== 2'd0 || out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset: got state=%0d valid=%b in_ready=%b expected 0 0 1",
               state2, out_valid2, in_ready2);
    end
    @(negedge clk);
    rst = 1'b0;
    load2({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, 1'b0, 1'b0);
    collect2({8'd19, 8'd22, 8'd43, 8'd50}, "after_reset", 1'b0);
  endtask

  task automatic test_n4_latency;
    int n = 0;
    int got = 0;
    int cyc = 0;
    out_ready4 = 1'b1;
    for (int e = 0; e < 32; e++) begin
      @(negedge clk);
      in_valid4 = 1'b1;
      if (e < 16) in_data4 = ((e / 4) == (e % 4)) ? 8'd1 : 8'd0;
      else        in_data4 = 8'(e - 15);
    end
    @(negedge clk);
    in_valid4 = 1'b0;
    while (out_valid4 !== 1'b1 && n < 100) begin
      total++;
      if (in_ready4 !== 1'b0) begin
        bad++;
        $display("FAIL n4_in_ready_compute at %0d: got %b expected 0", n, in_ready4);
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 12) begin
      bad++;
      $display("FAIL n4_latency: got %0d edges expected 12", n);
    end
    while (got < 16 && cyc < 100) begin
      total++;
      if (out_valid4 !== 1'b1 || out_data4 !== 8'(got + 1) || in_ready4 !== 1'b0) begin
        bad++;
        $display("FAIL n4_out%0d: got valid=%b data=%0d in_ready=%b expected 1 %0d 0",
                 got, out_valid4, out_data4, in_ready4, got + 1);
      end
      got++;
      cyc++;
      @(negedge clk);
    end
    total++;
    if (done4 !== 1'b1 || in_ready4 !== 1'b1 || state4 !== 2'd0) begin
      bad++;
      $display("FAIL n4_end: got done=%b in_ready=%b state=%0d expected 1 1 0",
               done4, in_ready4, state4);
    end
    out_ready4 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_transpose;
    test_relu;
    test_saturation;
    test_back_to_back_stall;
    test_reset_mid;
    test_n4_latency;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
